// File: rtl/cacheline_adapter_pkg.sv
// Shared types and constants for the cache <-> banked-memory line adapter.
// Line addresses split as tag[31:9], set[8:5], offset[4:0].
package cacheline_adapter_pkg;

  localparam int LINE_WIDTH   = 256;
  localparam int BEAT_WIDTH   = 64;
  localparam int BEATS        = LINE_WIDTH / BEAT_WIDTH;
  localparam int CNT_WIDTH    = $clog2(BEATS);

  localparam int TAG_WIDTH    = 23;
  localparam int SET_WIDTH    = 4;
  localparam int OFFSET_WIDTH = 5;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_DATA,
    WR_DATA,
    RESP
  } adapter_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } stage_reg_t;

endpackage

// File: rtl/cacheline_adapter.sv
// Converts one 256-bit cache line request into a 4-beat 64-bit bmem burst and
// reassembles read beats into a line answered with a single-cycle dfp_resp.
module cacheline_adapter
  import cacheline_adapter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           dfp_addr,
  input  logic                  dfp_read,
  input  logic                  dfp_write,
  input  logic [LINE_WIDTH-1:0] dfp_wdata,
  output logic [LINE_WIDTH-1:0] dfp_rdata,
  output logic                  dfp_resp,
  output logic [31:0]           bmem_addr,
  output logic                  bmem_read,
  output logic                  bmem_write,
  output logic [BEAT_WIDTH-1:0] bmem_wdata,
  input  logic                  bmem_ready,
  input  logic [31:0]           bmem_raddr,
  input  logic [BEAT_WIDTH-1:0] bmem_rdata,
  input  logic                  bmem_rvalid
);

  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(BEATS - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  adapter_state_t        state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [31:0]           addr_q, addr_d;
  logic [LINE_WIDTH-1:0] line_q, line_d;
  logic [LINE_WIDTH-1:0] rdata_q, rdata_d;
  logic [BEAT_WIDTH-1:0] wdata_q, wdata_d;
  logic                  read_q, read_d;
  logic                  write_q, write_d;
  logic                  resp_q, resp_d;

  logic                  unused_offset;
  assign unused_offset = ^dfp_addr[OFFSET_WIDTH-1:0];

  // line_q doubles as the write-data latch and the read assembly buffer;
  // rdata_q only changes when a read completes so writes leave it intact.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    line_d  = line_q;
    rdata_d = rdata_q;
    wdata_d = wdata_q;
    read_d  = 1'b0;
    write_d = 1'b0;
    resp_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (dfp_read) begin
          addr_d  = {dfp_addr[31:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
          cnt_d   = '0;
          read_d  = 1'b1;
          state_d = RD_REQ;
        end else if (dfp_write) begin
          addr_d  = {dfp_addr[31:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
          line_d  = dfp_wdata;
          wdata_d = dfp_wdata[BEAT_WIDTH-1:0];
          cnt_d   = '0;
          write_d = 1'b1;
          state_d = WR_DATA;
        end
      end

      RD_REQ: begin
        if (bmem_ready) begin
          state_d = RD_DATA;
        end else begin
          read_d = 1'b1;
        end
      end

      RD_DATA: begin
        if (bmem_rvalid && (bmem_raddr == addr_q)) begin
          line_d[BEAT_WIDTH*int'(cnt_q) +: BEAT_WIDTH] = bmem_rdata;
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == LAST_BEAT) begin
            rdata_d = line_d;
            resp_d  = 1'b1;
            state_d = RESP;
          end
        end
      end

      WR_DATA: begin
        write_d = 1'b1;
        if (bmem_ready) begin
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == LAST_BEAT) begin
            write_d = 1'b0;
            resp_d  = 1'b1;
            state_d = RESP;
          end else begin
            wdata_d = line_q[BEAT_WIDTH*int'(cnt_d) +: BEAT_WIDTH];
          end
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      line_q  <= '0;
      rdata_q <= '0;
      wdata_q <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      line_q  <= line_d;
      rdata_q <= rdata_d;
      wdata_q <= wdata_d;
      read_q  <= read_d;
      write_q <= write_d;
      resp_q  <= resp_d;
    end
  end

  assign dfp_rdata  = rdata_q;
  assign dfp_resp   = resp_q;
  assign bmem_addr  = addr_q;
  assign bmem_read  = read_q;
  assign bmem_write = write_q;
  assign bmem_wdata = wdata_q;

endmodule

// File: doc/cacheline_adapter.md
# cacheline_adapter

Memory-side responder for the cache's downstream line port. Accepts one 256-bit line read or write from the cache (32-byte lines: tag[31:9], set[8:5], offset[4:0]) and converts it into a 4-beat, 64-bit burst on the banked-memory (bmem) interface. On the return path it reassembles the beats into a line and answers the cache with a single-cycle response. It sits between the cache and bmem and has exactly one transaction in flight.

## Interface
- LINE_WIDTH, 256, cache line width in bits
- BEAT_WIDTH, 64, bmem data beat width in bits; BEATS = LINE_WIDTH/BEAT_WIDTH = 4
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset (low = reset)
- dfp_addr  in  32  line request address; bits [4:0] are ignored
- dfp_read  in  1  line read request, level, held until dfp_resp
- dfp_write  in  1  line write request, level, held until dfp_resp
- dfp_wdata  in  256  write line; beat k = dfp_wdata[64k+63:64k]
- dfp_rdata  out  256  assembled read line, valid when dfp_resp=1
- dfp_resp  out  1  one-cycle completion pulse
- bmem_addr  out  32  line-aligned burst address ({line, 5'b0})
- bmem_read  out  1  read burst request
- bmem_write  out  1  write beat strobe
- bmem_wdata  out  64  current write beat
- bmem_ready  in  1  memory accepts request/beat this cycle
- bmem_raddr  in  32  address tag of the returning read beat
- bmem_rdata  in  64  returning read beat
- bmem_rvalid  in  1  read beat valid

## Operation
- States: IDLE, RD_REQ, RD_DATA, WR_DATA, RESP; 2-bit beat counter cnt.
- IDLE: if dfp_read, latch line address ({dfp_addr[31:5],5'b0}), cnt←0, go RD_REQ. Else if dfp_write, latch address and dfp_wdata, cnt←0, go WR_DATA. Both asserted (illegal): read wins, write ignored.
- RD_REQ: bmem_read=1, bmem_addr=latched address. On bmem_ready → RD_DATA; otherwise hold.
- RD_DATA: bmem_read=0. On bmem_rvalid with bmem_raddr==latched address: line[64·cnt +: 64]←bmem_rdata, cnt++. rvalid with mismatched raddr is dropped. Accepting beat cnt==3 → RESP. Beats need not be consecutive.
- WR_DATA: bmem_write=1, bmem_addr=latched address, bmem_wdata=beat cnt of latched line. On bmem_ready: cnt++; beat cnt==3 accepted → RESP. bmem_ready low: hold the same beat.
- RESP: dfp_resp=1 for exactly one cycle, then IDLE. dfp_rdata presents the assembled line and holds it until the next read completes; writes leave it unchanged.
- dfp_read/dfp_write sampled in RESP are ignored; the cache drops its request the cycle after dfp_resp, and IDLE accepts a new one starting the following cycle.
- Incoming cache data is latched at accept; dfp_wdata/dfp_addr changes afterward have no effect.

## Timing
- Reset (rst=0 at edge): state IDLE, cnt 0, dfp_resp 0, dfp_rdata 0, bmem_read 0, bmem_write 0, bmem_addr 0, bmem_wdata 0. Applies mid-burst: transaction abandoned, no dfp_resp, and late rvalid beats are ignored (IDLE).
- All outputs are registered or decoded from state/registers only; no combinational path dfp_* → bmem_* or bmem_* → dfp_*.
- Write, bmem_ready always 1: accept cycle 0, beats cycles 1–4, dfp_resp cycle 5.
- Read: accept cycle 0, bmem_read cycle 1 (ready=1), last beat at cycle N, dfp_resp cycle N+1.
- Back-to-back: the next request's earliest accept is 2 cycles after dfp_resp.

## Structure
- Shared package (alongside stage_reg_t): adapter_state_t enum, LINE_WIDTH/BEAT_WIDTH/BEATS constants, line-address helper widths (TAG=23, SET=4, OFFSET=5).
- No sub-module: FSM, counter, and line register stay flat in cacheline_adapter.

## Test plan
- Write line 0x1111…_4444… (beat k = 0x{k+1} repeated) to 0x0000_1040, ready=1 → bmem_write cycles 1–4 with beats 0x1111_1111_1111_1111…0x4444_4444_4444_4444, addr 0x0000_1040, dfp_resp at cycle 5.
- Read 0x0000_2064 → bmem_read one cycle at addr 0x0000_2060. Return beats A,B,C,D with gaps of 0/3/1 cycles → dfp_rdata = {D,C,B,A}, dfp_resp 1 cycle after D.
- Write with bmem_ready low on beat 2 for 3 cycles → beat 2 is held stable, 4 accepted beats total, dfp_resp 3 cycles late.
- Read with stray rvalid raddr=0x0000_3000 interleaved → stray beat ignored, line correct.
- dfp_read and dfp_write asserted together → only bmem_read is issued, no bmem_write.
- rst low during the 2nd read beat → all outputs 0 next cycle, no dfp_resp; remaining beats are ignored, and a subsequent read completes correctly.
